vfpu_lzc_norm: RTL

- Pipelined, multi-lane leading/trailing-zero counter with normalisation shift for the VFPU datapath.
- Sits between the vector operand unpack stage and the FP add/convert normalisation logic.
- Replaces the single-lane combinational leading-one detector.
- Elastic valid/ready handshake, 2-stage pipeline, per-transaction mode select, tag passthrough.

---
 rtl/vfpu_lzc_norm_pkg.sv | 23 ++
 rtl/vfpu_lzc_norm_lzc.sv | 77 +++++++
 rtl/vfpu_lzc_norm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vfpu_lzc_norm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hwpe_ctrl_vfpu_package
//  Description : Shared types and helpers for the VFPU leading/trailing-zero
//                counter and normalisation pipeline.
//                - vfpu_lzc_mode_t : count direction (leading / trailing)
//                - vfpu_lzc_cnt_w  : count width able to represent WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
package hwpe_ctrl_vfpu_package;

    typedef enum logic {
        LZC_LEADING  = 1'b0,
        LZC_TRAILING = 1'b1
    } vfpu_lzc_mode_t;

    // One extra bit over log2 so an all-zero lane can report exactly WIDTH.
    function automatic int vfpu_lzc_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vfpu_lzc_norm_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : vfpu_lzc
//  Description : Purely combinational single-lane zero counter built as a
//                balanced binary tree.  Trailing mode reuses the leading tree
//                on the bit-reversed input.
//  Ports       : data_i  [WIDTH]  lane data
//                mode_i  [1]      0 = leading, 1 = trailing
//                count_o [CNT_W]  zero count (WIDTH when lane is zero)
//                zero_o  [1]      lane is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module vfpu_lzc
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = vfpu_lzc_cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    localparam int C_LOG = $clog2(WIDTH);
    localparam int C_PAD = 1 << C_LOG;

    logic [WIDTH-1:0] w_scan;
    logic [C_PAD-1:0] w_padded;
    logic             w_vld [C_LOG+1][C_PAD];
    logic [C_LOG-1:0] w_cnt [C_LOG+1][C_PAD];

    // Bit-reverse for trailing mode so the tree always counts from the top.
    always_comb begin
        w_scan = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mode_i == LZC_TRAILING) begin
                w_scan[i] = data_i[WIDTH-1-i];
            end else begin
                w_scan[i] = data_i[i];
            end
        end
    end

    // Padding zeros go below the scanned vector, i.e. on the uncounted side.
    assign w_padded = C_PAD'(w_scan) << (C_PAD - WIDTH);

    // Node n of level l covers 2^l bits; node 0 is the most significant.
    // A node's count is the left count if the left half holds a one,
    // otherwise half-size plus the right count.
    always_comb begin
        for (int l = 0; l <= C_LOG; l++) begin
            for (int n = 0; n < C_PAD; n++) begin
                w_vld[l][n] = 1'b0;
                w_cnt[l][n] = '0;
            end
        end
        for (int n = 0; n < C_PAD; n++) begin
            w_vld[0][n] = w_padded[C_PAD-1-n];
        end
        for (int l = 1; l <= C_LOG; l++) begin
            for (int n = 0; n < C_PAD/2; n++) begin
                w_vld[l][n] = w_vld[l-1][2*n] | w_vld[l-1][2*n+1];
                if (w_vld[l-1][2*n]) begin
                    w_cnt[l][n] = w_cnt[l-1][2*n];
                end else begin
                    w_cnt[l][n] = w_cnt[l-1][2*n+1] | C_LOG'(1 << (l-1));
                end
            end
        end
    end

    assign zero_o  = ~w_vld[C_LOG][0];
    assign count_o = zero_o ? CNT_W'(WIDTH) : {1'b0, w_cnt[C_LOG][0]};

endmodule
`default_nettype wire

// File: rtl/vfpu_lzc_norm.sv
`default_nettype none
// ============================================================================
//  Module      : vfpu_lzc_norm
//  Description : Two-stage pipelined multi-lane leading/trailing zero counter
//                with normalisation shift and elastic valid/ready handshake.
//                S1 registers count/zero/raw data/mode/tag; S2 registers the
//                shifted data and drives the outputs directly.
//  Ports       : clk_i, rst_ni (async active-low), clear_i (sync flush)
//                in_valid_i / in_ready_o, in_data_i, in_mode_i, in_tag_i
//                out_valid_o / out_ready_i, out_data_o, out_count_o,
//                out_zero_o, out_tag_o
//  Revision    : 1.0 - initial release
// ============================================================================
module vfpu_lzc_norm
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int NUM_LANES = 2,
    parameter  int TAG_W     = 4,
    localparam int CNT_W     = vfpu_lzc_cnt_w(WIDTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [NUM_LANES*WIDTH-1:0] in_data_i,
    input  logic                       in_mode_i,
    input  logic [TAG_W-1:0]           in_tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_LANES*WIDTH-1:0] out_data_o,
    output logic [NUM_LANES*CNT_W-1:0] out_count_o,
    output logic [NUM_LANES-1:0]       out_zero_o,
    output logic [TAG_W-1:0]           out_tag_o
);

    // ---------------------------------------------------------------- lanes
    logic [NUM_LANES*CNT_W-1:0] w_lane_cnt;
    logic [NUM_LANES-1:0]       w_lane_zero;
    logic [NUM_LANES*WIDTH-1:0] w_shifted;

    logic                       r_s1_valid_q, w_s1_valid_d;
    logic [NUM_LANES*WIDTH-1:0] r_s1_data_q,  w_s1_data_d;
    logic [NUM_LANES*CNT_W-1:0] r_s1_cnt_q,   w_s1_cnt_d;
    logic [NUM_LANES-1:0]       r_s1_zero_q,  w_s1_zero_d;
    logic                       r_s1_mode_q,  w_s1_mode_d;
    logic [TAG_W-1:0]           r_s1_tag_q,   w_s1_tag_d;

    logic                       r_s2_valid_q, w_s2_valid_d;
    logic [NUM_LANES*WIDTH-1:0] r_s2_data_q,  w_s2_data_d;
    logic [NUM_LANES*CNT_W-1:0] r_s2_cnt_q,   w_s2_cnt_d;
    logic [NUM_LANES-1:0]       r_s2_zero_q,  w_s2_zero_d;
    logic [TAG_W-1:0]           r_s2_tag_q,   w_s2_tag_d;

    logic w_s2_ready;
    logic w_in_ready;
    logic w_accept;
    logic w_xfer;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        vfpu_lzc #(
            .WIDTH (WIDTH)
        ) u_lzc (
            .data_i  (in_data_i[k*WIDTH +: WIDTH]),
            .mode_i  (in_mode_i),
            .count_o (w_lane_cnt[k*CNT_W +: CNT_W]),
            .zero_o  (w_lane_zero[k])
        );

        // A zero lane shifts by WIDTH and so yields zero on its own.
        assign w_shifted[k*WIDTH +: WIDTH] =
            (r_s1_mode_q == LZC_TRAILING)
                ? (r_s1_data_q[k*WIDTH +: WIDTH] >> r_s1_cnt_q[k*CNT_W +: CNT_W])
                : (r_s1_data_q[k*WIDTH +: WIDTH] << r_s1_cnt_q[k*CNT_W +: CNT_W]);
    end

    // ------------------------------------------------------------ handshake
    assign w_s2_ready = ~r_s2_valid_q | out_ready_i;
    assign w_in_ready = (~r_s1_valid_q | w_s2_ready) & ~clear_i;
    assign w_accept   = in_valid_i & w_in_ready;
    // Flush wins over an S1->S2 move; the moved data would be invisible anyway.
    assign w_xfer     = r_s1_valid_q & w_s2_ready & ~clear_i;

    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_data_d  = r_s1_data_q;
        w_s1_cnt_d   = r_s1_cnt_q;
        w_s1_zero_d  = r_s1_zero_q;
        w_s1_mode_d  = r_s1_mode_q;
        w_s1_tag_d   = r_s1_tag_q;

        if (clear_i) begin
            w_s1_valid_d = 1'b0;
        end else if (w_accept) begin
            w_s1_valid_d = 1'b1;
        end else if (w_xfer) begin
            w_s1_valid_d = 1'b0;
        end

        if (w_accept) begin
            w_s1_data_d = in_data_i;
            w_s1_cnt_d  = w_lane_cnt;
            w_s1_zero_d = w_lane_zero;
            w_s1_mode_d = in_mode_i;
            w_s1_tag_d  = in_tag_i;
        end
    end

    always_comb begin
        w_s2_valid_d = r_s2_valid_q;
        w_s2_data_d  = r_s2_data_q;
        w_s2_cnt_d   = r_s2_cnt_q;
        w_s2_zero_d  = r_s2_zero_q;
        w_s2_tag_d   = r_s2_tag_q;

        if (clear_i) begin
            w_s2_valid_d = 1'b0;
        end else if (w_xfer) begin
            w_s2_valid_d = 1'b1;
        end else if (out_ready_i) begin
            w_s2_valid_d = 1'b0;
        end

        if (w_xfer) begin
            w_s2_data_d = w_shifted;
            w_s2_cnt_d  = r_s1_cnt_q;
            w_s2_zero_d = r_s1_zero_q;
            w_s2_tag_d  = r_s1_tag_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid_q <= 1'b0;
            r_s1_data_q  <= '0;
            r_s1_cnt_q   <= '0;
            r_s1_zero_q  <= '0;
            r_s1_mode_q  <= 1'b0;
            r_s1_tag_q   <= '0;
            r_s2_valid_q <= 1'b0;
            r_s2_data_q  <= '0;
            r_s2_cnt_q   <= '0;
            r_s2_zero_q  <= '0;
            r_s2_tag_q   <= '0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_data_q  <= w_s1_data_d;
            r_s1_cnt_q   <= w_s1_cnt_d;
            r_s1_zero_q  <= w_s1_zero_d;
            r_s1_mode_q  <= w_s1_mode_d;
            r_s1_tag_q   <= w_s1_tag_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_s2_data_q  <= w_s2_data_d;
            r_s2_cnt_q   <= w_s2_cnt_d;
            r_s2_zero_q  <= w_s2_zero_d;
            r_s2_tag_q   <= w_s2_tag_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_s2_valid_q;
    assign out_data_o  = r_s2_data_q;
    assign out_count_o = r_s2_cnt_q;
    assign out_zero_o  = r_s2_zero_q;
    assign out_tag_o   = r_s2_tag_q;

endmodule
`default_nettype wire
